dna_motif_matcher: RTL and testbench
====================================

Name: dna_motif_matcher

Overview:
Streaming DNA motif detector, parametrised successor to the fixed 4-base sequence FSM. Holds a runtime-programmable motif of up to MAX_LEN bases, with a per-base wildcard mask. Compares a sliding window of the incoming 2-bit base stream against the motif and detects overlapping occurrences. Reports a registered match pulse, the stream position of each hit, and a saturating hit count; sits directly on the base stream, upstream of host/status logic.

Parameters:
MAX_LEN, 16, maximum motif length in bases (>=2)
CNTW, 16, match_count width
POSW, 32, stream position counter width
RST_LEN, 4, motif length loaded at reset (0..MAX_LEN)
RST_PATTERN, {(MAX_LEN-4){2'b00}, 2'b10, 2'b11, 2'b01, 2'b00}, reset motif; base i occupies bits [2i+1:2i], index 0 = oldest base
Derived (localparams): IDXW = $clog2(MAX_LEN); LENW = $clog2(MAX_LEN+1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of history, position and count
in_valid  in  1  dna_in valid this cycle
dna_in  in  2  base code
cfg_we  in  1  write one motif entry
cfg_idx  in  IDXW  motif entry index
cfg_base  in  2  motif base for entry
cfg_care  in  1  1 = compare entry, 0 = wildcard
cfg_len_we  in  1  write motif length
cfg_len  in  LENW  motif length in bases
match  out  1  registered one-cycle hit pulse
match_pos  out  POSW  position of base that completed the last hit
match_count  out  CNTW  saturating hit count
fill_full  out  1  history holds >= current length bases

Behaviour:
- Reset (rst_n=0, async): history=0, fill=0, pos=0, match=0, match_pos=0, match_count=0. Motif = RST_PATTERN, all care bits=1, len=RST_LEN.
- Base accepted when in_valid=1 and clear=0. An accepted base shifts into the history (newest at top); fill increments, saturating at MAX_LEN; pos increments, wrapping at 2^POSW.
- Hit condition, evaluated combinationally on the window that includes the base being accepted:
  - 1 <= len <= MAX_LEN;
  - fill+1 >= len;
  - for every i < len: care[i]=0, or window base i equals pattern[i]. Window base len-1 is the base being accepted; window base 0 is the oldest base in the window.
- Latency: match=1 in the cycle after the accepting edge, otherwise 0. On the same edge: match_pos <= pos of the accepted base (0-based since last clear/reset), and match_count <= match_count+1, saturating at all-ones.
- Overlapping hits are all reported. There is no restart-on-hit: a hit on base k does not block a hit on base k+1.
- Idle cycles (in_valid=0) do not disturb history, fill, or pos. Accepted bases need not be contiguous in time.
- match_pos and match_count hold their values between hits.
- len=0 or len>MAX_LEN: never hit. Bases are still accepted.
- Config:
  - cfg_we writes pattern[cfg_idx]/care[cfg_idx]; cfg_idx >= MAX_LEN is ignored.
  - cfg_len_we writes len.
  - Any cfg write (cfg_we or cfg_len_we) sets fill=0 on the same edge, so no hit spans old and new config.
  - A base accepted in the same cycle as a cfg write is compared against the old config. fill ends at 0 on that edge; the base itself stays in history.
  - cfg_we and cfg_len_we may assert in the same cycle; both apply.
- clear=1 takes priority over in_valid: the base is discarded, and history, fill, pos, match_count, match_pos and match are set to 0 next cycle. Config is untouched.
- clear and a cfg write in the same cycle: both take effect.
- Reset asserted mid-stream drops all partial windows. The first hit after reset needs len fresh bases.
- fill_full = (fill >= len) && (len != 0). Registered-state derived, no input paths.

Decomposition:
- Package dna_pkg:
  - base codes BASE_A=2'b00, BASE_C=2'b01, BASE_G=2'b10, BASE_T=2'b11;
  - typedef dna_base_t (logic [1:0]);
  - MAX_LEN default constant.
- Sub-module dna_window_cmp: purely combinational. Inputs: window, pattern, care mask, len. Output: per-entry equality and the hit flag. Reusable by future multi-motif variants.
- Top holds history, fill, pos, config registers and output registers.

Test Plan:
- Reset defaults; stream 00,01,11,10 with in_valid=1 -> match high in the cycle after the 4th base; match_pos=3, match_count=1.
- cfg_len=2, pattern 00,00; stream 00 x4 -> three match pulses; match_pos 1,2,3; match_count=3 (overlap).
- Pattern 00,01,11,10 with care[1]=0; stream 00,10,11,10 -> hit. Stream 01,10,11,10 -> no hit.
- Default motif fed with in_valid gaps (1-3 idle cycles between bases) -> single hit, match_pos=3. A cfg_len_we mid-motif suppresses the hit.
- CNTW=4, len=1, pattern 00; stream 00 x20 -> match_count reaches 15 and holds; match pulses every accepted base.
- clear together with in_valid on the 3rd base of the default motif, then 01,11,10 -> no hit. rst_n low mid-stream -> outputs return to 0 asynchronously.

Source files
------------

// File: rtl/dna_motif_matcher_pkg.sv
// Shared base encodings and defaults for the DNA motif matching blocks.
package dna_pkg;

    typedef logic [1:0] dna_base_t;

    localparam dna_base_t BASE_A = 2'b00;
    localparam dna_base_t BASE_C = 2'b01;
    localparam dna_base_t BASE_G = 2'b10;
    localparam dna_base_t BASE_T = 2'b11;

    localparam int MAX_LEN_DEF = 16;

endpackage

// File: rtl/dna_motif_matcher_window_cmp.sv
// Combinational window-versus-motif compare; entry 0 of window and pattern is the oldest base.
module dna_window_cmp
    import dna_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LENW    = $clog2(MAX_LEN + 1)
) (
    input  logic [2*MAX_LEN-1:0] i_window,
    input  logic [2*MAX_LEN-1:0] i_pattern,
    input  logic [MAX_LEN-1:0]   i_care,
    input  logic [LENW-1:0]      i_len,
    output logic [MAX_LEN-1:0]   o_eq,
    output logic                 o_hit
);

    logic w_all;

    always_comb begin
        o_eq  = '0;
        w_all = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            o_eq[i] = (i_window[2*i +: 2] == i_pattern[2*i +: 2]);
            if ((i < int'(i_len)) && i_care[i] && !o_eq[i]) begin
                w_all = 1'b0;
            end
        end
        o_hit = w_all && (i_len != '0) && (int'(i_len) <= MAX_LEN);
    end

endmodule

// File: rtl/dna_motif_matcher.sv
// Streaming motif detector: history shift register, fill/position tracking,
// runtime motif configuration and registered hit reporting.
module dna_motif_matcher
    import dna_pkg::*;
#(
    parameter int                   MAX_LEN     = MAX_LEN_DEF,
    parameter int                   CNTW        = 16,
    parameter int                   POSW        = 32,
    parameter int                   RST_LEN     = 4,
    parameter logic [2*MAX_LEN-1:0] RST_PATTERN = (2*MAX_LEN)'(8'hB4),
    localparam int                  IDXW        = $clog2(MAX_LEN),
    localparam int                  LENW        = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    input  dna_base_t       dna_in,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_idx,
    input  dna_base_t       cfg_base,
    input  logic            cfg_care,
    input  logic            cfg_len_we,
    input  logic [LENW-1:0] cfg_len,
    output logic            match,
    output logic [POSW-1:0] match_pos,
    output logic [CNTW-1:0] match_count,
    output logic            fill_full
);

    logic [2*MAX_LEN-1:0] r_hist;
    logic [2*MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-1:0]   r_care;
    logic [LENW-1:0]      r_len;
    logic [LENW-1:0]      r_fill;
    logic [POSW-1:0]      r_pos;
    logic                 r_match;
    logic [POSW-1:0]      r_mpos;
    logic [CNTW-1:0]      r_cnt;

    logic                 w_accept;
    logic                 w_cfg;
    logic [2*MAX_LEN-1:0] w_next_hist;
    logic [2*MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0]   w_eq_unused;
    logic                 w_cmp_hit;
    logic                 w_fill_ok;
    logic                 w_hit;

    assign w_accept    = in_valid & ~clear;
    assign w_cfg       = cfg_we | cfg_len_we;
    assign w_next_hist = {dna_in, r_hist[2*MAX_LEN-1:2]};

    // Newest base sits at the top entry; shifting down aligns the last len bases to entry 0.
    always_comb begin
        w_window = '0;
        if ((r_len != '0) && (int'(r_len) <= MAX_LEN)) begin
            w_window = w_next_hist >> (2 * (MAX_LEN - int'(r_len)));
        end
    end

    dna_window_cmp #(
        .MAX_LEN (MAX_LEN),
        .LENW    (LENW)
    ) u_cmp (
        .i_window  (w_window),
        .i_pattern (r_pat),
        .i_care    (r_care),
        .i_len     (r_len),
        .o_eq      (w_eq_unused),
        .o_hit     (w_cmp_hit)
    );

    assign w_fill_ok = ({1'b0, r_fill} + (LENW+1)'(1)) >= {1'b0, r_len};
    assign w_hit     = w_accept & w_cmp_hit & w_fill_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat  <= RST_PATTERN;
            r_care <= '1;
            r_len  <= LENW'(RST_LEN);
        end else begin
            if (cfg_we && (int'(cfg_idx) < MAX_LEN)) begin
                r_pat[2*cfg_idx +: 2] <= cfg_base;
                r_care[cfg_idx]       <= cfg_care;
            end
            if (cfg_len_we) begin
                r_len <= cfg_len;
            end
        end
    end

    // Any config write restarts the fill so no hit spans old and new motif.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pos   <= '0;
            r_match <= 1'b0;
            r_mpos  <= '0;
            r_cnt   <= '0;
        end else if (clear) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pos   <= '0;
            r_match <= 1'b0;
            r_mpos  <= '0;
            r_cnt   <= '0;
        end else begin
            r_match <= w_hit;
            if (w_accept) begin
                r_hist <= w_next_hist;
                r_pos  <= r_pos + POSW'(1);
            end
            if (w_cfg) begin
                r_fill <= '0;
            end else if (w_accept && (int'(r_fill) < MAX_LEN)) begin
                r_fill <= r_fill + LENW'(1);
            end
            if (w_hit) begin
                r_mpos <= r_pos;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end
        end
    end

    assign match       = r_match;
    assign match_pos   = r_mpos;
    assign match_count = r_cnt;
    assign fill_full   = (r_fill >= r_len) && (r_len != '0);

endmodule

// File: tb/tb_dna_motif_matcher.sv
// Directed plus randomized bench for dna_motif_matcher against a queue-based motif model.
module tb_dna_motif_matcher;

    localparam int ML = 8;
    localparam int CW = 4;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic [1:0]    dna_in;
    logic          cfg_we;
    logic [2:0]    cfg_idx;
    logic [1:0]    cfg_base;
    logic          cfg_care;
    logic          cfg_len_we;
    logic [3:0]    cfg_len;
    logic          match;
    logic [PW-1:0] match_pos;
    logic [CW-1:0] match_count;
    logic          fill_full;

    dna_motif_matcher #(
        .MAX_LEN (ML),
        .CNTW    (CW),
        .POSW    (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .dna_in      (dna_in),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_base    (cfg_base),
        .cfg_care    (cfg_care),
        .cfg_len_we  (cfg_len_we),
        .cfg_len     (cfg_len),
        .match       (match),
        .match_pos   (match_pos),
        .match_count (match_count),
        .fill_full   (fill_full)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;

    logic [1:0]  m_pat [ML];
    bit          m_care[ML];
    int          m_len;
    logic [1:0]  seq[$];
    int unsigned m_pos;
    int          m_cnt;
    int unsigned m_mpos;
    bit          m_match;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int fill;
        fill = seq.size();
        chk({tag, "_match"}, 32'(match), 32'(m_match));
        chk({tag, "_pos"}, match_pos, m_mpos);
        chk({tag, "_cnt"}, 32'(match_count), 32'(m_cnt));
        chk({tag, "_full"}, 32'(fill_full), 32'((fill >= m_len) && (m_len != 0)));
    endtask

    task automatic model_reset();
        logic [7:0] def;
        def = 8'hB4;
        for (int i = 0; i < ML; i++) begin
            m_pat[i]  = (i < 4) ? def[2*i +: 2] : 2'b00;
            m_care[i] = 1'b1;
        end
        m_len   = 4;
        seq.delete();
        m_pos   = 0;
        m_cnt   = 0;
        m_mpos  = 0;
        m_match = 1'b0;
    endtask

    // The window is the last len bases accepted since the last fill restart, ending with b.
    function automatic bit model_hit(input logic [1:0] b);
        int n;
        logic [1:0] x;
        if (m_len < 1 || m_len > ML) return 1'b0;
        n = seq.size() + 1;
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            int k;
            k = n - m_len + i;
            x = (k == n - 1) ? b : seq[k];
            if (m_care[i] && (x != m_pat[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cyc(input bit v, input bit [1:0] b, input bit clr, input bit we, input int idx,
                       input bit [1:0] cb, input bit cc, input bit lwe, input int ln, input string tag);
        bit acc;
        bit h;
        in_valid   = v;
        dna_in     = b;
        clear      = clr;
        cfg_we     = we;
        cfg_idx    = idx[2:0];
        cfg_base   = cb;
        cfg_care   = cc;
        cfg_len_we = lwe;
        cfg_len    = ln[3:0];
        acc = v && !clr;
        h   = acc && model_hit(b);
        @(posedge clk);
        #1;
        if (clr) begin
            seq.delete();
            m_pos   = 0;
            m_cnt   = 0;
            m_mpos  = 0;
            m_match = 1'b0;
        end else begin
            m_match = h;
            if (h) begin
                m_mpos = m_pos;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
            if (acc) begin
                m_pos++;
                seq.push_back(b);
                if (seq.size() > ML) void'(seq.pop_front());
            end
        end
        if (we || lwe) seq.delete();
        if (we && idx < ML) begin
            m_pat[idx]  = cb;
            m_care[idx] = cc;
        end
        if (lwe) m_len = ln;
        in_valid   = 1'b0;
        clear      = 1'b0;
        cfg_we     = 1'b0;
        cfg_len_we = 1'b0;
        check_all(tag);
    endtask

    task automatic base(input bit [1:0] b, input string tag);
        cyc(1'b1, b, 1'b0, 1'b0, 0, 2'b00, 1'b0, 1'b0, 0, tag);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 0, 2'b00, 1'b0, 1'b0, 0, tag);
    endtask

    task automatic wpat(input int idx, input bit [1:0] b, input bit c, input bit clr);
        cyc(1'b0, 2'b00, clr, 1'b1, idx, b, c, 1'b0, 0, "cfgp");
    endtask

    task automatic wlen(input int ln, input bit clr);
        cyc(1'b0, 2'b00, clr, 1'b0, 0, 2'b00, 1'b0, 1'b1, ln, "cfgl");
    endtask

    task automatic set_default(input bit clr);
        wpat(0, 2'b00, 1'b1, 1'b0);
        wpat(1, 2'b01, 1'b1, 1'b0);
        wpat(2, 2'b11, 1'b1, 1'b0);
        wpat(3, 2'b10, 1'b1, 1'b0);
        wlen(4, clr);
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        dna_in     = 2'b00;
        cfg_we     = 1'b0;
        cfg_idx    = 3'd0;
        cfg_base   = 2'b00;
        cfg_care   = 1'b0;
        cfg_len_we = 1'b0;
        cfg_len    = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        rst_n = 1'b1;

        // Reset motif detection.
        base(2'b00, "d0");
        base(2'b01, "d1");
        base(2'b11, "d2");
        chk("d2_nomatch", 32'(match), 32'd0);
        base(2'b10, "d3");
        chk("d3_match", 32'(match), 32'd1);
        chk("d3_pos", match_pos, 32'd3);
        chk("d3_cnt", 32'(match_count), 32'd1);
        idle("d_idle");

        // Overlapping hits with a 2-base motif.
        wpat(0, 2'b00, 1'b1, 1'b0);
        wpat(1, 2'b00, 1'b1, 1'b0);
        wlen(2, 1'b1);
        for (int i = 0; i < 4; i++) base(2'b00, "ovl");
        chk("ovl_pos", match_pos, 32'd3);
        chk("ovl_cnt", 32'(match_count), 32'd3);

        // Wildcard entry 1.
        set_default(1'b1);
        wpat(1, 2'b01, 1'b0, 1'b0);
        base(2'b00, "wc");
        base(2'b10, "wc");
        base(2'b11, "wc");
        base(2'b10, "wc_hit");
        chk("wc_match", 32'(match), 32'd1);
        base(2'b01, "wc2");
        base(2'b10, "wc2");
        base(2'b11, "wc2");
        base(2'b10, "wc2_end");
        chk("wc2_nomatch", 32'(match), 32'd0);

        // Gapped stream, then a length write mid-motif.
        set_default(1'b1);
        base(2'b00, "gap");
        idle("gap");
        base(2'b01, "gap");
        idle("gap");
        idle("gap");
        base(2'b11, "gap");
        repeat (3) idle("gap");
        base(2'b10, "gap_hit");
        chk("gap_match", 32'(match), 32'd1);
        chk("gap_pos", match_pos, 32'd3);
        base(2'b00, "sup");
        base(2'b01, "sup");
        wlen(4, 1'b0);
        base(2'b11, "sup");
        base(2'b10, "sup_end");
        chk("sup_nomatch", 32'(match), 32'd0);

        // Count saturation with a single-base motif.
        wpat(0, 2'b00, 1'b1, 1'b0);
        wlen(1, 1'b1);
        for (int i = 0; i < 20; i++) base(2'b00, "sat");
        chk("sat_cnt", 32'(match_count), 32'd15);
        chk("sat_pos", match_pos, 32'd19);
        chk("sat_match", 32'(match), 32'd1);

        // Clear on the third base discards the partial window.
        set_default(1'b1);
        base(2'b00, "clr");
        base(2'b01, "clr");
        cyc(1'b1, 2'b11, 1'b1, 1'b0, 0, 2'b00, 1'b0, 1'b0, 0, "clr_c");
        base(2'b01, "clr");
        base(2'b11, "clr");
        base(2'b10, "clr_end");
        chk("clr_nomatch", 32'(match), 32'd0);

        // Out-of-range lengths never hit.
        wlen(0, 1'b0);
        for (int i = 0; i < 4; i++) base(2'b00, "len0");
        wlen(12, 1'b0);
        for (int i = 0; i < 12; i++) base(2'b00, "len12");

        // Randomized mix of bases, idles, clears and config writes.
        for (int it = 0; it < 600; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                base(2'($urandom_range(0, 3)), "rnd_b");
            end else if (r < 82) begin
                idle("rnd_i");
            end else if (r < 86) begin
                cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1, 1'b0, 0,
                    2'b00, 1'b0, 1'b0, 0, "rnd_c");
            end else if (r < 94) begin
                cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'b1, $urandom_range(0, ML - 1), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) != 0), 1'b0, 0, "rnd_p");
            end else begin
                int ln;
                ln = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
                cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0,
                    1'($urandom_range(0, 1)), $urandom_range(0, ML - 1), 2'($urandom_range(0, 3)),
                    1'b1, 1'b1, ln, "rnd_l");
            end
        end

        // Asynchronous reset right after a hit.
        set_default(1'b1);
        base(2'b00, "ar");
        base(2'b01, "ar");
        base(2'b11, "ar");
        base(2'b10, "ar_hit");
        chk("ar_pre_match", 32'(match), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_match", 32'(match), 32'd0);
        chk("ar_pos", match_pos, 32'd0);
        chk("ar_cnt", 32'(match_count), 32'd0);
        chk("ar_full", 32'(fill_full), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base(2'b01, "post");
        base(2'b11, "post");
        base(2'b10, "post");
        chk("post_nomatch", 32'(match), 32'd0);
        base(2'b00, "post");
        base(2'b01, "post");
        base(2'b11, "post");
        base(2'b10, "post_hit");
        chk("post_match", 32'(match), 32'd1);
        chk("post_pos", match_pos, 32'd6);
        idle("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
